program_loader: RTL and testbench



---
 rtl/program_loader.sv | 140 ++++++++++++++
 tb/tb_program_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: boot-time byte-stream loader for the MIPS instruction ROM.
// Takes a word count followed by big-endian 32-bit instructions. It writes each
// instruction to program memory and holds the core in reset until the whole
// image has been loaded.
// Optional build macro: PROGRAM_LOADER_CHECKSUM_EN appends an XOR checksum byte
// that must match before the core is released.
module program_loader #(
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        cpu_reset_o,
  output logic        done_o,
  output logic        error_o,
  output logic [7:0]  words_loaded_o
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, DONE, ERROR} state_t;
`endif

  state_t      state;
  state_t      state_next;
  logic [7:0]  word_count;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_word;
  logic        xfer;
  logic        count_bad;
  logic        last_byte;
  logic        last_word;
  logic        done_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // The loader accepts bytes in every state that still expects input
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign rx_ready_o = (state == IDLE) || (state == LOAD) || (state == CHECK);
`else
  assign rx_ready_o = (state == IDLE) || (state == LOAD);
`endif
  assign xfer      = rx_valid_i && rx_ready_o;
  assign count_bad = (rx_data_i == 8'd0) || ({24'd0, rx_data_i} > MEMORY_DEPTH);
  assign last_byte = (byte_cnt == 2'd3);
  assign last_word = ((words_loaded_o + 8'd1) == word_count);

  // The done flag rises one cycle after the DONE state is entered from LOAD.
  // After a checksum pass it rises together with the state change.
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign done_next = (state == DONE) || ((state == CHECK) && (state_next == DONE));
`else
  assign done_next = (state == DONE);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (xfer) state_next = count_bad ? ERROR : LOAD;
      end
      LOAD: begin
        if (xfer && last_byte && last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer) state_next = (rx_data_i == csum) ? DONE : ERROR;
      end
`endif
      DONE:    state_next = DONE;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  // Holds the upper three bytes of the word being assembled. Data only, so no reset.
  always_ff @(posedge clk) begin
    if (xfer && (state == LOAD)) asm_word <= {asm_word[15:0], rx_data_i};
  end

  // Control, counters and the registered memory write port
  always_ff @(posedge clk) begin
    if (reset) begin
      word_count     <= 8'd0;
      byte_cnt       <= 2'd0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= BASE_ADDR;
      mem_data_o     <= 32'd0;
      words_loaded_o <= 8'd0;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
      cpu_reset_o    <= 1'b1;
    end else begin
      mem_we_o    <= 1'b0;
      done_o      <= done_next;
      error_o     <= (state_next == ERROR);
      cpu_reset_o <= !done_next;
      if (xfer && (state == IDLE)) word_count <= rx_data_i;
      if (xfer && (state == LOAD)) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (last_byte) begin
          mem_we_o       <= 1'b1;
          mem_data_o     <= {asm_word, rx_data_i};
          mem_addr_o     <= BASE_ADDR + {22'd0, words_loaded_o, 2'b00};
          words_loaded_o <= words_loaded_o + 8'd1;
        end
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // Running XOR over the count byte and every image byte
  always_ff @(posedge clk) begin
    if (reset)                                         csum <= 8'd0;
    else if (xfer && ((state == IDLE) || (state == LOAD))) csum <= csum ^ rx_data_i;
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed boundary cases plus randomized images
// checked against a word-level reference model.
module tb_program_loader;
  localparam int unsigned DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [7:0]  words_loaded;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  program_loader #(.MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .rx_ready_o     (rx_ready),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_data),
    .cpu_reset_o    (cpu_reset),
    .done_o         (done),
    .error_o        (error),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  // Record every memory write pulse
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rx_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Offer one byte after gap idle cycles and wait (bounded) for it to be taken
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    rx_valid = 1'b0;
    repeat (gap) step();
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = rx_ready;
      step();
      if (ok) break;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    rx_valid = 1'b0;
  endtask

  // Reference model: n random words go to BASE+4k in order. The image is accepted
  // only if the count is legal and, when enabled, the checksum matches.
  task automatic run_image(input int n, input int max_gap, input bit good_csum);
    logic [31:0] words[$];
    logic [7:0]  x;
    logic [31:0] w;
    bit          ok;
    ok = 1'b1;
    x  = 8'(n);
    send_byte(8'(n), $urandom_range(0, max_gap));
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      words.push_back(w);
      for (int s = 3; s >= 0; s--) begin
        x = x ^ w[8*s +: 8];
        send_byte(w[8*s +: 8], $urandom_range(0, max_gap));
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ok = good_csum;
    send_byte(good_csum ? x : (x ^ 8'(1 + $urandom_range(0, 254))), $urandom_range(0, max_gap));
`else
    if (!good_csum) ok = 1'b1;
`endif
    repeat (3) step();
    @(negedge clk);
    check("img_nwrites", wr_addr_q.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < wr_addr_q.size()) begin
        check($sformatf("img_addr%0d", k), wr_addr_q[k], BASE + 32'(4 * k));
        check($sformatf("img_data%0d", k), wr_data_q[k], words[k]);
      end
    end
    check("img_words", words_loaded, n);
    check("img_done", done, ok);
    check("img_error", error, !ok);
    check("img_cpu_reset", cpu_reset, !ok);
    check("img_ready", rx_ready, 0);
    step();
  endtask

  initial begin
    logic [7:0] bad_counts[3];
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", rx_ready, 1);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, BASE);
    check("rst_data", mem_data, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words", words_loaded, 0);
    step();

    // Single word, back-to-back bytes, exact latency of the release
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    @(negedge clk);
    check("t1_we", mem_we, 1);
    check("t1_addr", mem_addr, 32'h0);
    check("t1_data", mem_data, 32'h2008_0005);
    check("t1_words", words_loaded, 1);
    check("t1_done_early", done, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check("t1_cpu_reset_early", cpu_reset, 1);
    step();
    send_byte(8'h2C, 0);
    @(negedge clk);
`else
    step();
    @(negedge clk);
    check("t1_we_off", mem_we, 0);
`endif
    check("t1_done", done, 1);
    check("t1_cpu_reset", cpu_reset, 0);
    check("t1_nwrites", wr_addr_q.size(), 1);

    // Bytes offered while DONE are refused and change nothing
    step();
    rx_data  = 8'hFF;
    rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_ready", rx_ready, 0);
      check("hold_we", mem_we, 0);
      step();
    end
    rx_valid = 1'b0;
    @(negedge clk);
    check("hold_nwrites", wr_addr_q.size(), 1);
    check("hold_words", words_loaded, 1);
    check("hold_data", mem_data, 32'h2008_0005);
    check("hold_done", done, 1);
    check("hold_cpu_reset", cpu_reset, 0);
    step();

    // Illegal counts
    bad_counts[0] = 8'h00;
    bad_counts[1] = 8'(DEPTH + 1);
    bad_counts[2] = 8'($urandom_range(DEPTH + 2, 255));
    for (int i = 0; i < 3; i++) begin
      do_reset();
      send_byte(bad_counts[i], 0);
      @(negedge clk);
      check("badn_error_next", error, 1);
      repeat (2) step();
      @(negedge clk);
      check("badn_error", error, 1);
      check("badn_cpu_reset", cpu_reset, 1);
      check("badn_done", done, 0);
      check("badn_ready", rx_ready, 0);
      check("badn_nwrites", wr_addr_q.size(), 0);
      step();
    end

    // Reset mid-load, with a byte offered on the reset edge
    do_reset();
    send_byte(8'h02, 0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
    rx_data  = 8'hAB;
    rx_valid = 1'b1;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    check("mid_we", mem_we, 0);
    check("mid_addr", mem_addr, BASE);
    check("mid_data", mem_data, 0);
    check("mid_words", words_loaded, 0);
    check("mid_cpu_reset", cpu_reset, 1);
    check("mid_done", done, 0);
    check("mid_error", error, 0);
    check("mid_ready", rx_ready, 1);
    step();
    wr_addr_q.delete();
    wr_data_q.delete();
    run_image(1, 0, 1'b1);

    // Randomized images, including the full-depth boundary
    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_image((i == 0) ? int'(DEPTH) : int'($urandom_range(1, 6)), (i < 3) ? 2 : 0, 1'b1);
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Known checksum image, good and bad
    for (int j = 0; j < 2; j++) begin
      do_reset();
      send_byte(8'h01, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'h56, 0);
      send_byte(8'h78, 0);
      send_byte((j == 0) ? 8'h09 : 8'h00, 0);
      step();
      @(negedge clk);
      check("cs_data", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hDEAD_BEEF, 32'h1234_5678);
      check("cs_done", done, (j == 0));
      check("cs_error", error, (j == 1));
      check("cs_cpu_reset", cpu_reset, (j == 1));
      step();
    end
    do_reset();
    run_image($urandom_range(1, 4), 1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
